iob_native_rr_arbiter: RTL and testbench

//  Shares one IOb-native slave port (e.g. the tester UART register port) between two
//  IOb-native masters in system_top: the CPU-side bus and the bench/tester driver.

---
 rtl/iob_native_rr_arbiter_pkg.sv | 5 +
 rtl/iob_rr_arb2.sv | 16 +
 rtl/iob_native_rr_arbiter.sv | 73 +++++++
 tb/tb_iob_native_rr_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/iob_native_rr_arbiter_pkg.sv
// iob_native_rr_arbiter_pkg: shared FSM encoding and default error word for the IOb 2:1 arbiter
package iob_native_rr_arbiter_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;
  localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;
endpackage

// File: rtl/iob_rr_arb2.sv
// iob_rr_arb2: two-requester round-robin grant with a last-grant register
module iob_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_upd_gnt,
  output logic       o_gnt
);
  logic r_last;
  // on a tie the requester that did not win last time goes next
  assign o_gnt = (&i_req) ? ~r_last : i_req[1];
  always_ff @(posedge clk)
    if (rst) r_last <= 1'b1;
    else if (i_upd) r_last <= i_upd_gnt;
endmodule

// File: rtl/iob_native_rr_arbiter.sv
// iob_native_rr_arbiter: shares one IOb-native slave between two masters, round-robin with watchdog
module iob_native_rr_arbiter
  import iob_native_rr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT_W = 8,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_ready,
  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_ready,
  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_ready,
  output logic                timeout
);
  state_t                r_state, w_state_nxt;
  logic                  r_gnt;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic                  w_arb_gnt, w_busy, w_done, w_tout, w_fin, w_req;
  logic [DATA_W-1:0]     w_rdata;
  iob_rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     ({m1_valid, m0_valid}),
    .i_upd     (w_fin),
    .i_upd_gnt (r_gnt),
    .o_gnt     (w_arb_gnt)
  );
  // gating with rst keeps every output low in the reset cycle even if the FSM was BUSY
  assign w_busy  = (r_state == ST_BUSY) & ~rst;
  assign w_req   = m0_valid | m1_valid;
  assign w_done  = w_busy & s_ready;
  assign w_tout  = w_busy & ~s_ready & (&r_wdog);
  assign w_fin   = w_done | w_tout;
  assign w_rdata = w_tout ? ERR_DATA : s_rdata;
  always_comb
    w_state_nxt = (r_state == ST_IDLE) ? (w_req ? ST_BUSY : ST_IDLE) : (w_fin ? ST_IDLE : ST_BUSY);
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_req) r_gnt <= w_arb_gnt;
      r_wdog <= w_fin ? '0 : (w_busy ? r_wdog + TIMEOUT_W'(1) : r_wdog);
    end
  assign s_valid  = w_busy & ~w_tout & (r_gnt ? m1_valid : m0_valid);
  assign s_addr   = w_busy ? (r_gnt ? m1_addr : m0_addr) : '0;
  assign s_wdata  = w_busy ? (r_gnt ? m1_wdata : m0_wdata) : '0;
  assign s_wstrb  = w_busy ? (r_gnt ? m1_wstrb : m0_wstrb) : '0;
  assign m0_ready = w_fin & ~r_gnt;
  assign m1_ready = w_fin & r_gnt;
  assign m0_rdata = (w_busy & ~r_gnt) ? w_rdata : '0;
  assign m1_rdata = (w_busy & r_gnt) ? w_rdata : '0;
  assign timeout  = w_tout;
endmodule

// File: tb/tb_iob_native_rr_arbiter.sv
// tb_iob_native_rr_arbiter: directed + random check of the 2:1 arbiter against a transaction model
module tb_iob_native_rr_arbiter;
  localparam int AW = 32, DW = 32, SW = 4, TW = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mv = '0;
  logic [AW-1:0] ma[2] = '{default: '0};
  logic [DW-1:0] md[2] = '{default: '0};
  logic [SW-1:0] ms[2] = '{default: '0};
  logic [DW-1:0] m0_rdata, m1_rdata, s_wdata, s_rdata = '0;
  logic m0_ready, m1_ready, s_valid, s_ready = 1'b0, timeout;
  logic [AW-1:0] s_addr;
  logic [SW-1:0] s_wstrb;
  int checks = 0, failures = 0;
  int own = -1, age = 0, last = 1;
  logic [1:0] done;
  int order[$];

  iob_native_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .m0_valid(mv[0]), .m0_addr(ma[0]), .m0_wdata(md[0]), .m0_wstrb(ms[0]),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_valid(mv[1]), .m1_addr(ma[1]), .m1_wdata(md[1]), .m1_wstrb(ms[1]),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_rdata(s_rdata), .s_ready(s_ready), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // model: one owner at a time, aged per busy cycle; completion on s_ready or at the watchdog limit
  task automatic eval();
    logic [1:0] e_rdy;
    logic [DW-1:0] e_rd[2];
    logic e_sv, e_to;
    logic [AW-1:0] e_sa;
    logic [DW-1:0] e_sd;
    logic [SW-1:0] e_ss;
    #1;
    e_rdy = '0; e_rd = '{default: '0}; e_sv = 0; e_to = 0; e_sa = '0; e_sd = '0; e_ss = '0;
    if (!rst && own >= 0) begin
      e_to = !s_ready && age == (1 << TW) - 1;
      e_sv = mv[own] && !e_to;
      e_sa = ma[own]; e_sd = md[own]; e_ss = ms[own];
      e_rdy[own] = s_ready || e_to;
      e_rd[own] = e_to ? 32'hDEADBEEF : s_rdata;
    end
    chk("s_valid", s_valid, e_sv);
    chk("s_addr", s_addr, e_sa);
    chk("s_wdata", s_wdata, e_sd);
    chk("s_wstrb", s_wstrb, e_ss);
    chk("m0_ready", m0_ready, e_rdy[0]);
    chk("m1_ready", m1_ready, e_rdy[1]);
    chk("m0_rdata", m0_rdata, e_rd[0]);
    chk("m1_rdata", m1_rdata, e_rd[1]);
    chk("timeout", timeout, e_to);
    done = e_rdy;
    if (e_rdy[0]) order.push_back(0);
    if (e_rdy[1]) order.push_back(1);
    if (rst) begin own = -1; age = 0; last = 1; end
    else if (own < 0) begin
      if (mv != 0) begin own = (mv == 2'b11) ? 1 - last : (mv[1] ? 1 : 0); age = 0; end
    end else if (e_rdy[own]) begin last = own; own = -1; end
    else age++;
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin eval(); nxt(); end
  endtask

  task automatic do_reset();
    rst = 1; run(2); rst = 0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    // single read, slave responds three cycles after s_valid
    mv = 2'b01; ma[0] = 32'h4; ms[0] = '0;
    eval(); chk("rd_c0_sv", s_valid, 0); nxt();
    eval(); chk("rd_c1_sv", s_valid, 1); chk("rd_c1_addr", s_addr, 32'h4); nxt();
    run(2);
    s_ready = 1; s_rdata = 32'h12345678;
    eval(); chk("rd_rdy", m0_ready, 1); chk("rd_data", m0_rdata, 32'h12345678); chk("rd_m1", m1_ready, 0); nxt();
    mv = 0; s_ready = 0; run(1);
    // tie after reset, zero-wait slave: strict alternation starting with m0
    do_reset();
    order.delete();
    mv = 2'b11; s_ready = 1; ma[1] = 32'h40;
    run(16);
    chk("tie_cnt", order.size(), 8);
    foreach (order[k]) chk($sformatf("tie_ord%0d", k), order[k], k % 2);
    mv = 0; s_ready = 0; run(1);
    // m1 write with partial strobes
    mv = 2'b10; md[1] = 32'hA5A5A5A5; ms[1] = 4'b0011; ma[1] = 32'h10;
    eval(); nxt();
    s_ready = 1;
    eval(); chk("wr_sv", s_valid, 1); chk("wr_d", s_wdata, 32'hA5A5A5A5); chk("wr_s", s_wstrb, 4'b0011);
    chk("wr_m0r", m0_ready, 0); chk("wr_m1r", m1_ready, 1); nxt();
    mv = 0; s_ready = 0; run(1);
    // watchdog expiry then a late s_ready that must be ignored
    mv = 2'b01; ma[0] = 32'h8;
    for (int i = 0; i <= 16; i++) begin
      eval();
      chk($sformatf("to_%0d", i), timeout, i == 16);
      if (i == 16) begin chk("to_rdy", m0_ready, 1); chk("to_data", m0_rdata, 32'hDEADBEEF); chk("to_sv", s_valid, 0); end
      nxt();
    end
    mv = 0; run(1);
    s_ready = 1; eval(); chk("late_rdy", m0_ready, 0); nxt(); s_ready = 0;
    // s_ready on the last watchdog cycle wins
    mv = 2'b01;
    for (int i = 0; i <= 16; i++) begin
      if (i == 16) begin s_ready = 1; s_rdata = 32'hCAFEF00D; end
      eval();
      if (i == 16) begin chk("race_to", timeout, 0); chk("race_rdy", m0_ready, 1); chk("race_d", m0_rdata, 32'hCAFEF00D); end
      nxt();
    end
    mv = 0; s_ready = 0; run(1);
    // reset in the middle of an m1 access, then a tie goes to m0
    mv = 2'b10; ma[0] = 32'h100; ma[1] = 32'h200;
    run(2);
    rst = 1; eval(); chk("rst_sv", s_valid, 0); chk("rst_addr", s_addr, 0); nxt();
    rst = 0; mv = 2'b11; s_ready = 1;
    eval(); chk("rst_after", s_valid, 0); chk("rst_late", m1_ready, 0); nxt();
    s_ready = 0;
    eval(); chk("rst_tie_sv", s_valid, 1); chk("rst_tie_addr", s_addr, 32'h100); nxt();
    s_ready = 1; run(1); s_ready = 0; mv = 0; run(1);
    // random traffic with stall windows long enough to hit the watchdog
    for (int c = 0; c < 4000; c++) begin
      for (int x = 0; x < 2; x++)
        if (!mv[x] && $urandom_range(0, 2) == 0) begin
          mv[x] = 1; ma[x] = $urandom; md[x] = $urandom; ms[x] = SW'($urandom);
        end
      s_ready = ((c / 50) % 3 == 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
      s_rdata = $urandom;
      rst = ($urandom_range(0, 399) == 0);
      eval();
      for (int x = 0; x < 2; x++) if (done[x]) mv[x] = 0;
      nxt();
    end
    rst = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
